// File: rtl/tensor_pkg.sv
// rtl/tensor_pkg.sv - shared tensor datapath types for the dot-product operand path
package tensor_pkg;

  localparam int DEF_LANES  = 1;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_TAG_W  = 4;

  typedef logic [DEF_DATA_W-1:0] fp32_t;
  typedef fp32_t [DEF_LANES-1:0] opvec_t;

  localparam fp32_t FP32_POS_ZERO = 32'h0000_0000;

  typedef struct packed {
    opvec_t                 a;
    opvec_t                 b;
    logic [DEF_LANES-1:0]   mask;
    logic [DEF_TAG_W-1:0]   tag;
    logic                   last;
  } beat_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN
  } seq_state_t;

endpackage

// File: rtl/dot_operand_fifo.sv
// rtl/dot_operand_fifo.sv - small operand beat FIFO with occupancy count and flush
module dot_operand_fifo #(
  parameter type beat_t = tensor_pkg::beat_t,
  parameter int  DEPTH  = 3,
  parameter int  CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             flush,
  input  logic             push,
  input  beat_t            push_beat,
  input  logic             pop,
  output beat_t            head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  beat_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && !flush && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && !flush && (count != '0);

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_beat;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/dot_operand_sequencer.sv
// rtl/dot_operand_sequencer.sv - reads A/B operand groups and issues masked LANES-wide beats to the dot unit
module dot_operand_sequencer
  import tensor_pkg::*;
#(
  parameter int LANES   = 1,
  parameter int DATA_W  = 32,
  parameter int MAX_LEN = 64,
  parameter int ADDR_W  = 8,
  parameter int TAG_W   = 4,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst_ni,
  input  logic                    flush,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [LEN_W-1:0]        req_len,
  input  logic [ADDR_W-1:0]       req_base,
  input  logic [TAG_W-1:0]        req_tag,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic [LANES*DATA_W-1:0] rd_data_a,
  input  logic [LANES*DATA_W-1:0] rd_data_b,
  output logic                    op_valid,
  input  logic                    op_ready,
  output logic [LANES*DATA_W-1:0] op_a,
  output logic [LANES*DATA_W-1:0] op_b,
  output logic [LANES-1:0]        op_mask,
  output logic [TAG_W-1:0]        op_tag,
  output logic                    op_last,
  output logic                    busy
);

  typedef struct packed {
    logic [LANES*DATA_W-1:0] a;
    logic [LANES*DATA_W-1:0] b;
    logic [LANES-1:0]        mask;
    logic [TAG_W-1:0]        tag;
    logic                    last;
  } op_beat_t;

  seq_state_t         state_q;
  logic [LEN_W-1:0]   len_q;
  logic [ADDR_W-1:0]  base_q;
  logic [TAG_W-1:0]   tag_q;
  logic [LEN_W-1:0]   grp_q;
  logic [LEN_W:0]     elem_q;
  logic               inflight_q;
  logic [LANES-1:0]   pend_mask_q;
  logic               pend_last_q;

  logic [1:0]         fifo_count;
  logic               fifo_push;
  logic               fifo_pop;
  op_beat_t           push_beat;
  op_beat_t           head_beat;

  logic               accept;
  logic               room;
  logic               issue;
  logic               issue_last;
  logic [LANES-1:0]   issue_mask;
  logic [LEN_W+1:0]   remain;

  assign accept = (state_q == ST_IDLE) && req_valid && !flush;

  // Read gating looks only at registered occupancy, never at op_ready.
  always_comb begin
    room       = ({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd3;
    issue      = (state_q == ST_FETCH) && room && !flush;
    remain     = {2'b00, len_q} - {1'b0, elem_q};
    issue_last = remain <= (LEN_W + 2)'(LANES);
    issue_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      issue_mask[i] = (LEN_W + 2)'(i) < remain;
    end
  end

  always_comb begin
    push_beat = '0;
    fifo_push = 1'b0;
    if (accept && (req_len == '0)) begin
      fifo_push      = 1'b1;
      push_beat.tag  = req_tag;
      push_beat.last = 1'b1;
    end else if (inflight_q && !flush) begin
      fifo_push      = 1'b1;
      push_beat.mask = pend_mask_q;
      push_beat.tag  = tag_q;
      push_beat.last = pend_last_q;
      for (int i = 0; i < LANES; i++) begin
        push_beat.a[i*DATA_W +: DATA_W] = pend_mask_q[i] ? rd_data_a[i*DATA_W +: DATA_W] : FP32_POS_ZERO;
        push_beat.b[i*DATA_W +: DATA_W] = pend_mask_q[i] ? rd_data_b[i*DATA_W +: DATA_W] : FP32_POS_ZERO;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      base_q      <= '0;
      tag_q       <= '0;
      grp_q       <= '0;
      elem_q      <= '0;
      inflight_q  <= 1'b0;
      pend_mask_q <= '0;
      pend_last_q <= 1'b0;
    end else if (flush) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pend_mask_q <= issue_mask;
        pend_last_q <= issue_last;
        grp_q       <= grp_q + 1'b1;
        elem_q      <= elem_q + (LEN_W + 1)'(LANES);
      end
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            len_q   <= req_len;
            base_q  <= req_base;
            tag_q   <= req_tag;
            grp_q   <= '0;
            elem_q  <= '0;
            state_q <= (req_len == '0) ? ST_DRAIN : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (issue && issue_last) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!inflight_q && (fifo_count == 2'd0)) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  dot_operand_fifo #(
    .beat_t (op_beat_t),
    .DEPTH  (3),
    .CNT_W  (2)
  ) u_fifo (
    .clk       (clk),
    .rst_ni    (rst_ni),
    .flush     (flush),
    .push      (fifo_push),
    .push_beat (push_beat),
    .pop       (fifo_pop),
    .head      (head_beat),
    .count     (fifo_count)
  );

  assign fifo_pop  = op_valid && op_ready;
  assign op_valid  = fifo_count != 2'd0;
  assign op_a      = op_valid ? head_beat.a    : '0;
  assign op_b      = op_valid ? head_beat.b    : '0;
  assign op_mask   = op_valid ? head_beat.mask : '0;
  assign op_tag    = op_valid ? head_beat.tag  : '0;
  assign op_last   = op_valid && head_beat.last;

  assign req_ready = state_q == ST_IDLE;
  assign rd_en     = issue;
  assign rd_addr   = base_q + ADDR_W'(grp_q);
  assign busy      = (state_q != ST_IDLE) || op_valid;

endmodule

// File: tb/tb_dot_operand_sequencer.sv
// tb/tb_dot_operand_sequencer.sv - randomized self-checking bench for dot_operand_sequencer
module tb_dot_operand_sequencer;

  localparam int LANES   = 4;
  localparam int DATA_W  = 32;
  localparam int MAX_LEN = 64;
  localparam int ADDR_W  = 8;
  localparam int TAG_W   = 4;
  localparam int LEN_W   = 7;
  localparam int VW      = LANES * DATA_W;

  typedef struct packed {
    logic [VW-1:0]    a;
    logic [VW-1:0]    b;
    logic [LANES-1:0] mask;
    logic [TAG_W-1:0] tag;
    logic             last;
  } tb_beat_t;

  logic              clk;
  logic              rst_ni;
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic [LEN_W-1:0]  req_len;
  logic [ADDR_W-1:0] req_base;
  logic [TAG_W-1:0]  req_tag;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [VW-1:0]     rd_data_a;
  logic [VW-1:0]     rd_data_b;
  logic              op_valid;
  logic              op_ready;
  logic [VW-1:0]     op_a;
  logic [VW-1:0]     op_b;
  logic [LANES-1:0]  op_mask;
  logic [TAG_W-1:0]  op_tag;
  logic              op_last;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_opv = -1;

  logic [VW-1:0] mem_a [256];
  logic [VW-1:0] mem_b [256];

  tb_beat_t          obs_q[$];
  int                obs_cyc_q[$];
  logic [ADDR_W-1:0] rd_q[$];
  int                rd_cyc_q[$];

  dot_operand_sequencer #(
    .LANES(LANES), .DATA_W(DATA_W), .MAX_LEN(MAX_LEN),
    .ADDR_W(ADDR_W), .TAG_W(TAG_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_ni(rst_ni), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len),
    .req_base(req_base), .req_tag(req_tag),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .op_mask(op_mask), .op_tag(op_tag), .op_last(op_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Operand buffer: data valid exactly one cycle after rd_en, garbage otherwise.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem_a[rd_addr];
      rd_data_b <= mem_b[rd_addr];
    end else begin
      rd_data_a <= {$urandom, $urandom, $urandom, $urandom};
      rd_data_b <= {$urandom, $urandom, $urandom, $urandom};
    end
  end

  always @(negedge clk) begin
    if (rst_ni) begin
      if (rd_en) begin
        rd_q.push_back(rd_addr);
        rd_cyc_q.push_back(cyc);
      end
      if (op_valid && first_opv < 0) first_opv = cyc;
      if (op_valid && op_ready) begin
        obs_q.push_back('{op_a, op_b, op_mask, op_tag, op_last});
        obs_cyc_q.push_back(cyc);
      end
    end
  end

  function automatic int num_groups(input int len);
    return (len == 0) ? 1 : (len + LANES - 1) / LANES;
  endfunction

  function automatic tb_beat_t model_beat(input int len, input int base, input int tag, input int g);
    tb_beat_t e;
    logic [VW-1:0] wa;
    logic [VW-1:0] wb;
    logic [31:0] t;
    e  = '0;
    t  = tag;
    wa = mem_a[(base + g) % 256];
    wb = mem_b[(base + g) % 256];
    e.tag  = t[TAG_W-1:0];
    e.last = (g == num_groups(len) - 1);
    for (int i = 0; i < LANES; i++) begin
      if (g * LANES + i < len) begin
        e.mask[i] = 1'b1;
        e.a[i*DATA_W +: DATA_W] = wa[i*DATA_W +: DATA_W];
        e.b[i*DATA_W +: DATA_W] = wb[i*DATA_W +: DATA_W];
      end
    end
    return e;
  endfunction

  task automatic clear_mon();
    obs_q.delete();
    obs_cyc_q.delete();
    rd_q.delete();
    rd_cyc_q.delete();
    first_opv = -1;
  endtask

  task automatic send_req(input int len, input int base, input int tag, output int acc);
    int n = 0;
    req_len   = LEN_W'(len);
    req_base  = ADDR_W'(base);
    req_tag   = TAG_W'(tag);
    req_valid = 1'b1;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL req_accept_timeout req_ready=%b required 1", req_ready);
    end
    acc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_idle_timeout busy=%b required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({req_ready, rd_en, rd_addr, op_valid, op_last, op_mask, op_tag, busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values got rdy=%b rd_en=%b addr=%h v=%b last=%b mask=%b tag=%h busy=%b required 1 0 00 0 0 0000 0 0",
               req_ready, rd_en, rd_addr, op_valid, op_last, op_mask, op_tag, busy);
    end
  endtask

  task automatic test_full_groups();
    int acc;
    int tag = $urandom_range(0, 15);
    clear_mon();
    op_ready = 1'b1;
    send_req(8, 8'h10, tag, acc);
    wait_idle("full");
    checks++;
    if (rd_q.size() != 2 || rd_q[0] !== 8'h10 || rd_q[1] !== 8'h11) begin
      errors++;
      $display("FAIL full_rd_addrs got n=%0d required 2 reads 10,11", rd_q.size());
    end
    checks++;
    if (rd_cyc_q.size() != 2 || rd_cyc_q[0] != acc + 1 || rd_cyc_q[1] != acc + 2) begin
      errors++;
      $display("FAIL full_rd_timing got first=%0d required %0d consecutive", (rd_cyc_q.size() > 0) ? rd_cyc_q[0] : -1, acc + 1);
    end
    checks++;
    if (first_opv != acc + 3) begin
      errors++;
      $display("FAIL full_latency got op_valid cycle %0d required %0d", first_opv, acc + 3);
    end
    checks++;
    if (obs_q.size() != 2) begin
      errors++;
      $display("FAIL full_beat_count got %0d required 2", obs_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < 2; k++) begin
      checks++;
      if (obs_q[k] !== model_beat(8, 8'h10, tag, k)) begin
        errors++;
        $display("FAIL full_beat%0d got mask=%b last=%b tag=%h required mask=1111 last=%0d", k, obs_q[k].mask, obs_q[k].last, obs_q[k].tag, k);
      end
    end
  endtask

  task automatic test_partial();
    int acc;
    int base = $urandom_range(0, 255);
    clear_mon();
    op_ready = 1'b1;
    send_req(5, base, 9, acc);
    wait_idle("partial");
    checks++;
    if (obs_q.size() != 2) begin
      errors++;
      $display("FAIL partial_beat_count got %0d required 2", obs_q.size());
    end else begin
      checks++;
      if (obs_q[1].mask !== 4'b0001 || obs_q[1].a[VW-1:DATA_W] !== '0 || obs_q[1].b[VW-1:DATA_W] !== '0 || obs_q[1].last !== 1'b1) begin
        errors++;
        $display("FAIL partial_tail got mask=%b a_hi=%h last=%b required 0001 0 1", obs_q[1].mask, obs_q[1].a[VW-1:DATA_W], obs_q[1].last);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_q[k] !== model_beat(5, base, 9, k)) begin
          errors++;
          $display("FAIL partial_beat%0d got a=%h required a=%h", k, obs_q[k].a, model_beat(5, base, 9, k).a);
        end
      end
    end
  endtask

  task automatic test_zero_len();
    int acc;
    clear_mon();
    op_ready = 1'b1;
    send_req(0, $urandom_range(0, 255), 7, acc);
    wait_idle("zero");
    checks++;
    if (rd_q.size() != 0) begin
      errors++;
      $display("FAIL zero_reads got %0d required 0", rd_q.size());
    end
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== tb_beat_t'({264'h0, 4'h0, 4'h7, 1'b1})) begin
      errors++;
      $display("FAIL zero_beat got n=%0d required one beat mask 0 data 0 tag 7 last 1", obs_q.size());
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_ready got %b required 1", req_ready);
    end
  endtask

  task automatic test_stall();
    int acc;
    int n = 0;
    int base = $urandom_range(0, 255);
    logic [2*VW+LANES+TAG_W:0] held;
    clear_mon();
    op_ready = 1'b0;
    send_req(32, base, 5, acc);
    while (!op_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    held = {op_a, op_b, op_mask, op_tag, op_last};
    checks++;
    if (held !== model_beat(32, base, 5, 0)) begin
      errors++;
      $display("FAIL stall_first_beat got mask=%b tag=%h required model beat 0", op_mask, op_tag);
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({op_valid, op_a, op_b, op_mask, op_tag, op_last} !== {1'b1, held}) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got valid=%b mask=%b required stable beat", k, op_valid, op_mask);
      end
    end
    checks++;
    if (rd_q.size() != 3) begin
      errors++;
      $display("FAIL stall_reads got %0d required 3", rd_q.size());
    end
    op_ready = 1'b1;
    wait_idle("stall");
    checks++;
    if (obs_q.size() != 8) begin
      errors++;
      $display("FAIL stall_beat_count got %0d required 8", obs_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < 8; k++) begin
      checks++;
      if (obs_q[k] !== model_beat(32, base, 5, k) || obs_cyc_q[k] != obs_cyc_q[0] + k) begin
        errors++;
        $display("FAIL stall_beat%0d got mask=%b cyc=%0d required model beat at cyc %0d", k, obs_q[k].mask, obs_cyc_q[k], obs_cyc_q[0] + k);
      end
    end
  endtask

  task automatic test_flush();
    int acc;
    int n = 0;
    int seen = 0;
    int base = $urandom_range(0, 255);
    int len2 = $urandom_range(1, 40);
    clear_mon();
    op_ready = 1'b1;
    send_req(32, base, 2, acc);
    while (obs_q.size() < 2 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    flush    = 1'b1;
    op_ready = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if ({op_valid, req_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL flush_next got valid=%b ready=%b busy=%b required 0 1 0", op_valid, req_ready, busy);
    end
    op_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (op_valid) seen++;
    end
    checks++;
    if (seen != 0 || obs_q.size() != 2) begin
      errors++;
      $display("FAIL flush_drop got late_valid=%0d beats=%0d required 0 and 2", seen, obs_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < 2; k++) begin
      checks++;
      if (obs_q[k] !== model_beat(32, base, 2, k)) begin
        errors++;
        $display("FAIL flush_beat%0d got mask=%b required model", k, obs_q[k].mask);
      end
    end
    clear_mon();
    base = $urandom_range(0, 255);
    send_req(len2, base, 11, acc);
    wait_idle("post_flush");
    checks++;
    if (obs_q.size() != num_groups(len2)) begin
      errors++;
      $display("FAIL post_flush_count got %0d required %0d", obs_q.size(), num_groups(len2));
    end
    for (int k = 0; k < obs_q.size() && k < num_groups(len2); k++) begin
      checks++;
      if (obs_q[k] !== model_beat(len2, base, 11, k)) begin
        errors++;
        $display("FAIL post_flush_beat%0d got mask=%b last=%b required model", k, obs_q[k].mask, obs_q[k].last);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    int base = $urandom_range(0, 255);
    int len2 = $urandom_range(1, 64);
    clear_mon();
    op_ready = 1'b0;
    send_req(64, base, 4, acc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    checks++;
    if ({rd_en, op_valid, busy} !== 3'b111) begin
      errors++;
      $display("FAIL rst_mid_pre got rd_en=%b valid=%b busy=%b required 1 1 1", rd_en, op_valid, busy);
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({rd_en, op_valid, busy, req_ready, op_mask, op_last} !== {4'b0001, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_async got rd_en=%b valid=%b busy=%b ready=%b mask=%b required 0 0 0 1 0000", rd_en, op_valid, busy, req_ready, op_mask);
    end
    @(negedge clk); #1;
    rst_ni   = 1'b1;
    op_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({op_valid, busy, rd_en} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_after got valid=%b busy=%b rd_en=%b required 0 0 0", op_valid, busy, rd_en);
    end
    clear_mon();
    send_req(len2, base, 6, acc);
    wait_idle("post_reset");
    checks++;
    if (obs_q.size() != num_groups(len2)) begin
      errors++;
      $display("FAIL post_reset_count got %0d required %0d", obs_q.size(), num_groups(len2));
    end
    for (int k = 0; k < obs_q.size() && k < num_groups(len2); k++) begin
      checks++;
      if (obs_q[k] !== model_beat(len2, base, 6, k)) begin
        errors++;
        $display("FAIL post_reset_beat%0d got mask=%b required model", k, obs_q[k].mask);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      int acc;
      int n = 0;
      int len  = (r == 0) ? 20 : (r == 1) ? MAX_LEN : $urandom_range(0, MAX_LEN);
      int base = (r == 0) ? 8'hFE : $urandom_range(0, 255);
      int tag  = $urandom_range(0, 15);
      int g    = num_groups(len);
      int nrd  = (len == 0) ? 0 : g;
      clear_mon();
      send_req(len, base, tag, acc);
      while (busy && n < 3000) begin
        @(posedge clk); #1;
        op_ready = ($urandom_range(0, 3) != 0);
        n++;
      end
      op_ready = 1'b1;
      checks++;
      if (busy || rd_q.size() != nrd) begin
        errors++;
        $display("FAIL rand%0d_reads got %0d busy=%b required %0d busy=0", r, rd_q.size(), busy, nrd);
      end
      for (int k = 0; k < rd_q.size() && k < nrd; k++) begin
        checks++;
        if (rd_q[k] !== ADDR_W'((base + k) % 256)) begin
          errors++;
          $display("FAIL rand%0d_addr%0d got %h required %h", r, k, rd_q[k], ADDR_W'((base + k) % 256));
        end
      end
      checks++;
      if (obs_q.size() != g) begin
        errors++;
        $display("FAIL rand%0d_beat_count got %0d required %0d", r, obs_q.size(), g);
      end
      for (int k = 0; k < obs_q.size() && k < g; k++) begin
        checks++;
        if (obs_q[k] !== model_beat(len, base, tag, k)) begin
          errors++;
          $display("FAIL rand%0d_beat%0d got mask=%b tag=%h last=%b required mask=%b tag=%h last=%b", r, k,
                   obs_q[k].mask, obs_q[k].tag, obs_q[k].last,
                   model_beat(len, base, tag, k).mask, model_beat(len, base, tag, k).tag, model_beat(len, base, tag, k).last);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = {$urandom, $urandom, $urandom, $urandom};
      mem_b[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    rst_ni    = 1'b1;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_len   = '0;
    req_base  = '0;
    req_tag   = '0;
    op_ready  = 1'b1;
    #1 rst_ni = 1'b0;
    #21 rst_ni = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_full_groups();
    test_partial();
    test_zero_len();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
